// File: rtl/uart_telemetry_host.sv
// UART telemetry host: parses "S:TTHH<TERM>" frames from a byte-level receiver and
// sends five-byte command frames "<C><tens>:<ones><TERM>" through a byte-level transmitter.
module uart_telemetry_host #(
  parameter bit         STRICT_BINARY = 1'b1,
  parameter logic [7:0] TERM          = 8'h0A
) (
  input  logic       clk_100Mhz,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] temperature,
  output logic [7:0] humidity,
  output logic       frame_valid,
  output logic       frame_err,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_char,
  input  logic [6:0] cmd_value,
  output logic       cmd_ready,
  output logic       cmd_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned VAL_W  = 7;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned IDX_W  = 3;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(4);
  localparam logic [VAL_W-1:0]  MAX_VAL  = VAL_W'(99);
  localparam logic [VAL_W-1:0]  TEN      = VAL_W'(10);
  localparam logic [BYTE_W-1:0] CH_S     = 8'h53;
  localparam logic [BYTE_W-1:0] CH_COLON = 8'h3A;
  localparam logic [BYTE_W-1:0] CH_0     = 8'h30;
  localparam logic [BYTE_W-1:0] CH_9     = 8'h39;
  localparam logic [BYTE_W-1:0] CH_A     = 8'h41;
  localparam logic [BYTE_W-1:0] CH_B     = 8'h42;
  localparam logic [BYTE_W-1:0] CH_C     = 8'h43;
  localparam logic [BYTE_W-1:0] CH_D     = 8'h44;
  localparam logic [BYTE_W-1:0] CH_L     = 8'h4C;

  typedef enum logic [2:0] {
    P_S, P_COLON, P_T1, P_T0, P_H1, P_H0, P_END
  } p_state_t;

  typedef enum logic [1:0] {
    C_IDLE, C_SEND, C_WAIT_HI, C_WAIT_LO
  } c_state_t;

  // ---------------------------------------------------------------- parser
  p_state_t           r_p_state;
  p_state_t           w_p_next;
  logic               w_frame_ok;
  logic               w_frame_abort;
  logic               w_is_digit;
  logic [DIG_W-1:0]   w_digit;
  logic [DIG_W-1:0]   r_t1;
  logic [DIG_W-1:0]   r_t0;
  logic [DIG_W-1:0]   r_h1;
  logic [DIG_W-1:0]   r_h0;
  logic [BYTE_W-1:0]  w_temp;
  logic [BYTE_W-1:0]  w_hum;

  assign w_is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
  assign w_digit    = DIG_W'(rx_data - CH_0);
  assign w_temp     = BYTE_W'(r_t1) * 8'd10 + BYTE_W'(r_t0);
  assign w_hum      = BYTE_W'(r_h1) * 8'd10 + BYTE_W'(r_h0);

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) r_p_state <= P_S;
    else     r_p_state <= w_p_next;
  end

  // One state step per received byte; an abort on 'S' resyncs straight to P_COLON
  always_comb begin
    w_p_next      = r_p_state;
    w_frame_ok    = 1'b0;
    w_frame_abort = 1'b0;
    if (rx_done) begin
      case (r_p_state)
        P_S:     if (rx_data == CH_S) w_p_next = P_COLON;
        P_COLON: if (rx_data == CH_COLON) w_p_next = P_T1; else w_frame_abort = 1'b1;
        P_T1:    if (w_is_digit) w_p_next = P_T0; else w_frame_abort = 1'b1;
        P_T0:    if (w_is_digit) w_p_next = P_H1; else w_frame_abort = 1'b1;
        P_H1:    if (w_is_digit) w_p_next = P_H0; else w_frame_abort = 1'b1;
        P_H0:    if (w_is_digit) w_p_next = P_END; else w_frame_abort = 1'b1;
        P_END: begin
          if (rx_data == TERM) begin
            w_p_next   = P_S;
            w_frame_ok = 1'b1;
          end else begin
            w_frame_abort = 1'b1;
          end
        end
        default: w_p_next = P_S;
      endcase
      if (w_frame_abort) w_p_next = (rx_data == CH_S) ? P_COLON : P_S;
    end
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_t1 <= '0;
      r_t0 <= '0;
      r_h1 <= '0;
      r_h0 <= '0;
    end else if (rx_done && w_is_digit) begin
      case (r_p_state)
        P_T1:    r_t1 <= w_digit;
        P_T0:    r_t0 <= w_digit;
        P_H1:    r_h1 <= w_digit;
        P_H0:    r_h0 <= w_digit;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      temperature <= '0;
      humidity    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= w_frame_ok;
      frame_err   <= w_frame_abort;
      if (w_frame_ok) begin
        temperature <= w_temp;
        humidity    <= w_hum;
      end
    end
  end

  // ---------------------------------------------------------------- command sender
  c_state_t           r_c_state;
  c_state_t           w_c_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic [DIG_W-1:0]   r_tens;
  logic [DIG_W-1:0]   r_ones;
  logic [VAL_W-1:0]   w_tens;
  logic [VAL_W-1:0]   w_ones;
  logic               w_char_ok;
  logic               w_bin_ok;
  logic               w_cmd_ok;
  logic               w_cmd_hit;
  logic               w_accept;
  logic               w_reject;
  logic               w_send;
  logic [BYTE_W-1:0]  w_tx_byte;
  logic [BYTE_W-1:0]  w_follow_byte;

  assign w_tens    = cmd_value / TEN;
  assign w_ones    = cmd_value % TEN;
  assign w_char_ok = (cmd_char == CH_A) || (cmd_char == CH_B) || (cmd_char == CH_C) ||
                     (cmd_char == CH_D) || (cmd_char == CH_L);
  assign w_bin_ok  = (w_tens <= VAL_W'(1)) && (w_ones <= VAL_W'(1));
  assign w_cmd_ok  = w_char_ok && (cmd_value <= MAX_VAL) && (!STRICT_BINARY || w_bin_ok);
  assign w_cmd_hit = cmd_valid && cmd_ready;
  assign w_accept  = w_cmd_hit && w_cmd_ok;
  assign w_reject  = w_cmd_hit && !w_cmd_ok;

  // Byte that follows the one at r_idx; byte 0 (the letter) is taken from cmd_char at acceptance
  always_comb begin
    w_follow_byte = TERM;
    case (r_idx)
      IDX_W'(0): w_follow_byte = CH_0 + BYTE_W'(r_tens);
      IDX_W'(1): w_follow_byte = CH_COLON;
      IDX_W'(2): w_follow_byte = CH_0 + BYTE_W'(r_ones);
      default:   w_follow_byte = TERM;
    endcase
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_c_state <= C_IDLE;
      r_idx     <= '0;
    end else begin
      r_c_state <= w_c_next;
      r_idx     <= w_idx_next;
    end
  end

  always_comb begin
    w_c_next   = r_c_state;
    w_idx_next = r_idx;
    w_send     = 1'b0;
    w_tx_byte  = '0;
    case (r_c_state)
      C_IDLE: begin
        if (w_accept) begin
          w_c_next   = C_SEND;
          w_idx_next = '0;
          w_send     = 1'b1;
          w_tx_byte  = cmd_char;
        end
      end
      C_SEND:    w_c_next = C_WAIT_HI;
      C_WAIT_HI: if (tx_busy) w_c_next = C_WAIT_LO;
      C_WAIT_LO: begin
        if (!tx_busy) begin
          if (r_idx == LAST_IDX) begin
            w_c_next = C_IDLE;
          end else begin
            w_c_next   = C_SEND;
            w_idx_next = r_idx + IDX_W'(1);
            w_send     = 1'b1;
            w_tx_byte  = w_follow_byte;
          end
        end
      end
      default: w_c_next = C_IDLE;
    endcase
  end

  // tx_data only changes when a new byte is launched, so it holds through the busy window
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      tx_data   <= '0;
      tx_start  <= 1'b0;
      cmd_ready <= 1'b0;
      cmd_err   <= 1'b0;
      r_tens    <= '0;
      r_ones    <= '0;
    end else begin
      tx_start  <= w_send;
      cmd_ready <= (w_c_next == C_IDLE);
      cmd_err   <= w_reject;
      if (w_send) tx_data <= w_tx_byte;
      if (w_accept) begin
        r_tens <= DIG_W'(w_tens);
        r_ones <= DIG_W'(w_ones);
      end
    end
  end

endmodule

// File: doc/uart_telemetry_host.md
UART_TELEMETRY_HOST -- requirements
Module: uart_telemetry_host

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter STRICT_BINARY, default 1: when 1, outgoing command digits SHALL be limited to 0/1.
REQ-003 Parameter TERM, default 8'h0A: frame terminator byte, used for both RX and TX.
REQ-004 clk_100Mhz  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 rx_data  in  8  received byte from the byte-level UART receiver.
REQ-007 rx_done  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-008 tx_data  out  8  byte to transmit.
REQ-009 tx_start  out  1  one-cycle request to the byte-level UART transmitter.
REQ-010 tx_busy  in  1  transmitter busy; rises the cycle after tx_start and falls when the stop bit ends.
REQ-011 temperature  out  8  last good telemetry temperature, binary 0-99.
REQ-012 humidity  out  8  last good telemetry humidity, binary 0-99.
REQ-013 frame_valid  out  1  one-cycle pulse when a good telemetry frame completes.
REQ-014 frame_err  out  1  one-cycle pulse when a telemetry frame is aborted.
REQ-015 cmd_valid  in  1  command request.
REQ-016 cmd_char  in  8  ASCII command letter: 'A', 'B', 'C', 'D' or 'L'.
REQ-017 cmd_value  in  7  command value 0-99; tens digit goes first, ones digit second.
REQ-018 cmd_ready  out  1  high when the sender can accept a command.
REQ-019 cmd_err  out  1  one-cycle pulse when a command is rejected.

Function
REQ-020 Telemetry parser: the parser SHALL accept frames of the form 'S' ':' D1 D0 D3 D2 TERM, where each D is ASCII '0'-'9'.
- States: P_S, P_COLON, P_T1, P_T0, P_H1, P_H0, P_END.
- The parser SHALL advance by one state only on an rx_done strobe.
REQ-021 In any state except P_S, an unexpected byte SHALL abort the frame, with these effects:
- frame_err pulses once.
- The parser returns to P_S.
- If the offending byte is 'S', the parser goes directly to P_COLON (resync).
REQ-022 In P_S, a non-'S' byte SHALL be discarded silently, with no frame_err.
REQ-023 On the TERM byte in P_END, the block SHALL update its outputs one cycle after that rx_done:
- temperature = (D1-'0')*10 + (D0-'0').
- humidity = (D3-'0')*10 + (D2-'0').
- frame_valid pulses once.
REQ-024 temperature and humidity SHALL hold their last good value and SHALL NOT change on aborted frames.
REQ-025 Command sender FSM states: C_IDLE, C_SEND, C_WAIT_HI, C_WAIT_LO.
- cmd_ready = 1 only in C_IDLE.
REQ-026 A command SHALL be accepted when cmd_valid and cmd_ready are both high.
- It is rejected if cmd_char is not one of A/B/C/D/L, if cmd_value > 99, or if STRICT_BINARY=1 and either digit is > 1.
- A rejected command pulses cmd_err in the next cycle, transmits nothing and leaves the FSM in C_IDLE.
REQ-027 An accepted command SHALL be latched and sent as 5 bytes: cmd_char, tens+'0', ':', ones+'0', TERM.
REQ-028 Per-byte handshake:
- C_SEND drives tx_data and pulses tx_start for exactly 1 cycle, then moves to C_WAIT_HI.
- C_WAIT_HI waits for tx_busy=1.
- C_WAIT_LO waits for tx_busy=0, then either sends the next byte or returns to C_IDLE after byte 5.
REQ-029 tx_data SHALL remain stable from tx_start until tx_busy falls.
REQ-030 cmd_char and cmd_value SHALL be sampled only at acceptance; later changes SHALL NOT affect a frame in flight.
REQ-031 Parser and sender SHALL be independent; simultaneous rx_done and cmd_valid SHALL both be serviced in the same cycle.
REQ-032 Digit arithmetic: tens = cmd_value/10 and ones = cmd_value%10, both computed on 7-bit values; results SHALL be ASCII digits '0'-'9'.

Reset
REQ-033 While rst is high, the block SHALL hold these reset values:
- Parser in P_S; sender in C_IDLE.
- temperature=0, humidity=0, tx_data=0.
- tx_start, frame_valid, frame_err and cmd_err = 0.
- cmd_ready = 0.
REQ-034 cmd_ready SHALL rise in the first clock after rst falls.
REQ-035 Reset in mid-frame or mid-command SHALL abandon the frame; no completion or error pulse is issued afterwards.

Verification
REQ-036 RX "S:2765\n" -> temperature=27, humidity=65, one frame_valid pulse, no frame_err.
REQ-037 RX "S:2X" then "S:0408\n" -> one frame_err at 'X', then temperature=4, humidity=8; values from before 'X' remain until the good frame.
REQ-038 RX "S:S:1199\n" -> one frame_err (resync on the second 'S'), then temperature=11, humidity=99.
REQ-039 cmd 'L', value 10, STRICT_BINARY=1, tx model with busy for 20 cycles -> bytes 4C 31 3A 30 0A, one tx_start per byte, cmd_ready low throughout.
REQ-040 cmd 'A', value 25 with STRICT_BINARY=1 -> cmd_err pulse, no tx_start; same with STRICT_BINARY=0 -> bytes 41 32 3A 35 0A.
REQ-041 Assert rst during byte 3 of a command -> tx_start stays low, and after reset a new cmd 'B', value 1 sends 42 30 3A 31 0A.
